// File: rtl/alu_cmd_sequencer_pkg.sv
// rtl/alu_cmd_sequencer_pkg.sv - shared types and constants for the ALU command sequencer
package alu_cmd_sequencer_pkg;

    localparam int WIDTH_DEF = 32;
    localparam int REGS_DEF  = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_XOR = 3'b011;
    localparam logic [2:0] OP_SUB = 3'b100;
    localparam logic [2:0] OP_SRA = 3'b101;
    localparam logic [2:0] OP_SL  = 3'b110;
    localparam logic [2:0] OP_NOR = 3'b111;

endpackage

// File: rtl/alu_cmd_sequencer_if.sv
// rtl/alu_cmd_sequencer_if.sv - command, external write, ALU and result signals of the sequencer
interface alu_cmd_sequencer_if
    import alu_cmd_sequencer_pkg::*;
#(
    parameter int REGS  = REGS_DEF,
    parameter int WIDTH = WIDTH_DEF
);
    localparam int AW = $clog2(REGS);

    logic             cmd_valid;
    logic             cmd_ready;
    logic [2:0]       cmd_op;
    logic [AW-1:0]    cmd_rd;
    logic [AW-1:0]    cmd_rs1;
    logic [AW-1:0]    cmd_rs2;
    logic             wr_en;
    logic [AW-1:0]    wr_addr;
    logic [WIDTH-1:0] wr_data;
    logic [WIDTH-1:0] alu_A;
    logic [WIDTH-1:0] alu_B;
    logic [2:0]       alu_select;
    logic [WIDTH-1:0] alu_out;
    logic             res_valid;
    logic             res_ready;
    logic [WIDTH-1:0] res_data;
    logic [AW-1:0]    res_rd;
    logic             res_zero;

    modport slave (
        input  cmd_valid, cmd_op, cmd_rd, cmd_rs1, cmd_rs2,
        input  wr_en, wr_addr, wr_data, alu_out, res_ready,
        output cmd_ready, alu_A, alu_B, alu_select,
        output res_valid, res_data, res_rd, res_zero
    );

    modport master (
        output cmd_valid, cmd_op, cmd_rd, cmd_rs1, cmd_rs2,
        output wr_en, wr_addr, wr_data, alu_out, res_ready,
        input  cmd_ready, alu_A, alu_B, alu_select,
        input  res_valid, res_data, res_rd, res_zero
    );

endinterface

// File: rtl/alu_regfile.sv
// rtl/alu_regfile.sv - register file, two async read ports, external write plus write-back
module alu_regfile #(
    parameter int REGS  = 8,
    parameter int WIDTH = 32,
    localparam int AW   = $clog2(REGS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [AW-1:0]    i_rs1_addr,
    input  logic [AW-1:0]    i_rs2_addr,
    output logic [WIDTH-1:0] o_rs1_data,
    output logic [WIDTH-1:0] o_rs2_data,
    input  logic             i_wb_en,
    input  logic [AW-1:0]    i_wb_addr,
    input  logic [WIDTH-1:0] i_wb_data,
    input  logic             i_wr_en,
    input  logic [AW-1:0]    i_wr_addr,
    input  logic [WIDTH-1:0] i_wr_data
);

    logic [WIDTH-1:0] r_mem [REGS];

    // write-back is assigned last so it overrides an external write to the same entry
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < REGS; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (i_wr_en && (i_wr_addr != '0)) begin
                r_mem[i_wr_addr] <= i_wr_data;
            end
            if (i_wb_en && (i_wb_addr != '0)) begin
                r_mem[i_wb_addr] <= i_wb_data;
            end
        end
    end

    assign o_rs1_data = (i_rs1_addr == '0) ? '0 : r_mem[i_rs1_addr];
    assign o_rs2_data = (i_rs2_addr == '0) ? '0 : r_mem[i_rs2_addr];

endmodule

// File: rtl/alu_cmd_sequencer.sv
// rtl/alu_cmd_sequencer.sv - issues register-addressed commands to an external ALU and returns results
module alu_cmd_sequencer
    import alu_cmd_sequencer_pkg::*;
#(
    parameter int REGS  = REGS_DEF,
    parameter int WIDTH = WIDTH_DEF
) (
    input logic clk,
    input logic rst_n,
    alu_cmd_sequencer_if.slave bus
);

    localparam int AW = $clog2(REGS);

    state_t           r_state;
    state_t           w_state_nxt;
    logic             w_cmd_ready;
    logic             w_accept;
    logic             w_wb_en;
    logic [WIDTH-1:0] w_rs1_data;
    logic [WIDTH-1:0] w_rs2_data;
    logic [AW-1:0]    r_rd;
    logic [WIDTH-1:0] r_alu_a;
    logic [WIDTH-1:0] r_alu_b;
    logic [2:0]       r_alu_sel;
    logic [WIDTH-1:0] r_res_data;
    logic [AW-1:0]    r_res_rd;
    logic             r_res_valid;
    logic             r_res_zero;

    alu_regfile #(.REGS(REGS), .WIDTH(WIDTH)) u_regfile (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_rs1_addr (bus.cmd_rs1),
        .i_rs2_addr (bus.cmd_rs2),
        .o_rs1_data (w_rs1_data),
        .o_rs2_data (w_rs2_data),
        .i_wb_en    (w_wb_en),
        .i_wb_addr  (r_rd),
        .i_wb_data  (bus.alu_out),
        .i_wr_en    (bus.wr_en),
        .i_wr_addr  (bus.wr_addr),
        .i_wr_data  (bus.wr_data)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cmd_ready = 1'b0;
        w_accept    = 1'b0;
        w_wb_en     = 1'b0;
        case (r_state)
            IDLE: begin
                w_cmd_ready = rst_n;
                if (bus.cmd_valid && rst_n) begin
                    w_accept    = 1'b1;
                    w_state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                w_wb_en     = 1'b1;
                w_state_nxt = RESP;
            end
            RESP: begin
                if (bus.res_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // operands are sampled from the pre-edge register file: no bypass from a same-cycle external write
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rd        <= '0;
            r_alu_a     <= '0;
            r_alu_b     <= '0;
            r_alu_sel   <= '0;
            r_res_data  <= '0;
            r_res_rd    <= '0;
            r_res_valid <= 1'b0;
            r_res_zero  <= 1'b0;
        end else begin
            if (w_accept) begin
                r_alu_a   <= w_rs1_data;
                r_alu_b   <= w_rs2_data;
                r_alu_sel <= bus.cmd_op;
                r_rd      <= bus.cmd_rd;
            end
            if (r_state == ISSUE) begin
                r_res_data  <= bus.alu_out;
                r_res_zero  <= (bus.alu_out == '0);
                r_res_rd    <= r_rd;
                r_res_valid <= 1'b1;
            end else if ((r_state == RESP) && bus.res_ready) begin
                r_res_valid <= 1'b0;
            end
        end
    end

    assign bus.cmd_ready  = w_cmd_ready;
    assign bus.alu_A      = r_alu_a;
    assign bus.alu_B      = r_alu_b;
    assign bus.alu_select = r_alu_sel;
    assign bus.res_valid  = r_res_valid;
    assign bus.res_data   = r_res_data;
    assign bus.res_rd     = r_res_rd;
    assign bus.res_zero   = r_res_zero;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// tb/tb_alu_cmd_sequencer.sv - randomized and directed bench with a transaction-level model
module tb_alu_cmd_sequencer;
    import alu_cmd_sequencer_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;
    bit   mon_en = 1'b0;

    always #5 clk = ~clk;

    alu_cmd_sequencer_if bus ();

    alu_cmd_sequencer dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    function automatic logic [31:0] alu_ref(input logic [31:0] a, input logic [31:0] b,
                                            input logic [2:0] op);
        case (op)
            3'b000:  return a & b;
            3'b001:  return a | b;
            3'b010:  return a + b;
            3'b011:  return a ^ b;
            3'b100:  return a - b;
            3'b101:  return $unsigned($signed(a) >>> b[4:0]);
            3'b110:  return a << b[4:0];
            default: return ~(a | b);
        endcase
    endfunction

    assign bus.alu_out = alu_ref(bus.alu_A, bus.alu_B, bus.alu_select);

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // transaction-level model: register contents, command in flight, result on offer
    logic [31:0] m_rf [8];
    bit          m_busy = 1'b0;
    bit          m_pend = 1'b0;
    bit          m_vis  = 1'b0;
    logic [2:0]  m_pend_rd, m_res_rd, m_op;
    logic [31:0] m_pend_val, m_res, m_a, m_b;

    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) m_rf[i] <= 32'h0;
            m_busy <= 1'b0;
            m_pend <= 1'b0;
            m_vis  <= 1'b0;
        end else begin
            if (bus.wr_en && bus.wr_addr != 3'd0) m_rf[bus.wr_addr] <= bus.wr_data;
            if (m_pend) begin
                if (m_pend_rd != 3'd0) m_rf[m_pend_rd] <= m_pend_val;
                m_vis    <= 1'b1;
                m_res    <= m_pend_val;
                m_res_rd <= m_pend_rd;
                m_pend   <= 1'b0;
            end
            if (m_vis && bus.res_ready) begin
                m_vis  <= 1'b0;
                m_busy <= 1'b0;
            end
            if (bus.cmd_valid && !m_busy) begin
                m_busy     <= 1'b1;
                m_pend     <= 1'b1;
                m_pend_rd  <= bus.cmd_rd;
                m_a        <= m_rf[bus.cmd_rs1];
                m_b        <= m_rf[bus.cmd_rs2];
                m_op       <= bus.cmd_op;
                m_pend_val <= alu_ref(m_rf[bus.cmd_rs1], m_rf[bus.cmd_rs2], bus.cmd_op);
            end
        end
    end

    always @(negedge clk) begin
        if (mon_en) begin
            chk("cmd_ready", 32'(bus.cmd_ready), 32'(rst_n && !m_busy));
            chk("res_valid", 32'(bus.res_valid), 32'(m_vis));
            if (m_vis) begin
                chk("res_data", bus.res_data, m_res);
                chk("res_rd", 32'(bus.res_rd), 32'(m_res_rd));
                chk("res_zero", 32'(bus.res_zero), 32'(m_res == 32'h0));
            end
            if (m_pend) begin
                chk("alu_A", bus.alu_A, m_a);
                chk("alu_B", bus.alu_B, m_b);
                chk("alu_select", 32'(bus.alu_select), 32'(m_op));
            end
        end
    end

    task automatic issue(input logic [2:0] op, input logic [2:0] rd, input logic [2:0] rs1,
                         input logic [2:0] rs2, output int waits);
        bit acc;
        acc   = 1'b0;
        waits = 0;
        bus.cmd_op  = op;
        bus.cmd_rd  = rd;
        bus.cmd_rs1 = rs1;
        bus.cmd_rs2 = rs2;
        bus.cmd_valid = 1'b1;
        while (!acc && waits < 50) begin
            @(negedge clk);
            acc = bus.cmd_ready;
            @(posedge clk);
            #1;
            waits++;
        end
        bus.cmd_valid = 1'b0;
        chk("issue_accept", 32'(acc), 32'd1);
    endtask

    // called right after acceptance with res_ready high; returns in the following IDLE cycle
    task automatic finish_cmd(input string nm, input logic [31:0] exp, input logic [2:0] exp_rd,
                              input bit collide);
        if (collide) begin
            bus.wr_en   = 1'b1;
            bus.wr_addr = exp_rd;
            bus.wr_data = 32'hDEAD_BEEF;
        end
        @(negedge clk);
        chk({nm, "_lat_issue"}, 32'(bus.res_valid), 32'd0);
        @(posedge clk);
        #1;
        bus.wr_en = 1'b0;
        @(negedge clk);
        chk({nm, "_lat_valid"}, 32'(bus.res_valid), 32'd1);
        chk({nm, "_data"}, bus.res_data, exp);
        chk({nm, "_rd"}, 32'(bus.res_rd), 32'(exp_rd));
        chk({nm, "_zero"}, 32'(bus.res_zero), 32'(exp == 32'h0));
        @(posedge clk);
        #1;
    endtask

    task automatic run_cmd(input string nm, input logic [2:0] op, input logic [2:0] rd,
                           input logic [2:0] rs1, input logic [2:0] rs2, input logic [31:0] exp);
        int w;
        issue(op, rd, rs1, rs2, w);
        finish_cmd(nm, exp, rd, 1'b0);
    endtask

    task automatic ext_wr(input logic [2:0] addr, input logic [31:0] data);
        bus.wr_en   = 1'b1;
        bus.wr_addr = addr;
        bus.wr_data = data;
        @(posedge clk);
        #1;
        bus.wr_en = 1'b0;
    endtask

    initial begin
        int  w;
        bit  seen;
        bit  took;
        bus.cmd_valid = 1'b0;
        bus.cmd_op = 3'd0; bus.cmd_rd = 3'd0; bus.cmd_rs1 = 3'd0; bus.cmd_rs2 = 3'd0;
        bus.wr_en = 1'b0; bus.wr_addr = 3'd0; bus.wr_data = 32'h0;
        bus.res_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst_n  = 1'b1;
        mon_en = 1'b1;
        @(negedge clk);
        chk("ready_after_reset", 32'(bus.cmd_ready), 32'd1);
        @(posedge clk);
        #1;

        ext_wr(3'd1, 32'h0000_00F0);
        ext_wr(3'd2, 32'h0000_0F0F);
        run_cmd("and", OP_AND, 3'd3, 3'd1, 3'd2, 32'h0000_0000);
        run_cmd("add", OP_ADD, 3'd3, 3'd1, 3'd2, 32'h0000_0FFF);
        run_cmd("xor_dep", OP_XOR, 3'd4, 3'd3, 3'd1, 32'h0000_0F0F);

        bus.res_ready = 1'b0;
        issue(OP_SUB, 3'd6, 3'd2, 3'd1, w);
        @(posedge clk);
        #1;
        bus.cmd_op = OP_ADD; bus.cmd_rd = 3'd7; bus.cmd_rs1 = 3'd6; bus.cmd_rs2 = 3'd1;
        bus.cmd_valid = 1'b1;
        repeat (5) begin
            @(negedge clk);
            chk("bp_valid", 32'(bus.res_valid), 32'd1);
            chk("bp_data", bus.res_data, 32'h0000_0E1F);
            chk("bp_rd", 32'(bus.res_rd), 32'd6);
            chk("bp_cmd_ready", 32'(bus.cmd_ready), 32'd0);
            @(posedge clk);
            #1;
        end
        bus.res_ready = 1'b1;
        issue(OP_ADD, 3'd7, 3'd6, 3'd1, w);
        chk("bp_accept_waits", 32'(w), 32'd2);
        finish_cmd("bp_next", 32'h0000_0F0F, 3'd7, 1'b0);

        run_cmd("nor_r0", OP_NOR, 3'd0, 3'd0, 3'd0, 32'hFFFF_FFFF);
        run_cmd("r0_after_wb", OP_OR, 3'd0, 3'd0, 3'd0, 32'h0000_0000);
        ext_wr(3'd0, 32'h1234_5678);
        run_cmd("r0_after_ext", OP_OR, 3'd0, 3'd0, 3'd0, 32'h0000_0000);

        issue(OP_ADD, 3'd5, 3'd1, 3'd2, w);
        finish_cmd("collide", 32'h0000_0FFF, 3'd5, 1'b1);
        run_cmd("r5_read", OP_OR, 3'd0, 3'd5, 3'd0, 32'h0000_0FFF);

        bus.res_ready = 1'b0;
        issue(OP_ADD, 3'd3, 3'd1, 3'd2, w);
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            seen = bus.res_valid;
        end
        chk("rst_reach_resp", 32'(seen), 32'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
            chk("rst_cmd_ready", 32'(bus.cmd_ready), 32'd0);
            chk("rst_res_valid", 32'(bus.res_valid), 32'd0);
            chk("rst_alu_A", bus.alu_A, 32'h0);
            chk("rst_alu_B", bus.alu_B, 32'h0);
            chk("rst_alu_select", 32'(bus.alu_select), 32'd0);
        end
        #1;
        rst_n = 1'b1;
        bus.res_ready = 1'b1;
        @(negedge clk);
        chk("rst_release_ready", 32'(bus.cmd_ready), 32'd1);
        @(posedge clk);
        #1;
        run_cmd("r3_after_rst", OP_OR, 3'd0, 3'd3, 3'd0, 32'h0000_0000);

        for (int cyc = 0; cyc < 4000; cyc++) begin
            @(negedge clk);
            took = bus.cmd_valid && bus.cmd_ready;
            @(posedge clk);
            #1;
            if (!bus.cmd_valid || took) begin
                bus.cmd_valid = ($urandom_range(0, 3) != 0);
                bus.cmd_op  = 3'($urandom_range(0, 7));
                bus.cmd_rd  = 3'($urandom_range(0, 7));
                bus.cmd_rs1 = 3'($urandom_range(0, 7));
                bus.cmd_rs2 = 3'($urandom_range(0, 7));
            end
            bus.wr_en   = ($urandom_range(0, 3) == 0);
            bus.wr_addr = 3'($urandom_range(0, 7));
            bus.wr_data = ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom;
            bus.res_ready = ($urandom_range(0, 2) != 0);
        end
        bus.cmd_valid = 1'b0;
        bus.wr_en = 1'b0;
        bus.res_ready = 1'b1;
        repeat (6) @(posedge clk);
        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
